// File: rtl/fp32_subtractor.sv
// rtl/fp32_subtractor.sv - IEEE-754 single-precision subtractor z = a - b with stb/ack handshakes
module fp32_subtractor (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [3:0] {
      GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD0, ADD1,
      NORM1, NORM2, ROUND, PACK, PUT_Z
   } state_t;

   state_t state, next_state;

   logic [31:0]        a, b;
   logic [26:0]        a_m, b_m;
   logic signed [9:0]  a_e, b_e, z_e;
   logic               a_s, b_s, z_s;
   logic [27:0]        sum;
   logic [23:0]        z_m;
   logic               guard, round_bit, sticky;

   logic               special_hit;
   logic [31:0]        special_z;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= GET_A;
      else     state <= next_state;
   end

   // Next-state decode; loops in ALIGN/NORM1/NORM2 run one shift per cycle
   always_comb begin
      next_state = state;
      case (state)
         GET_A:   if (input_a_stb && input_a_ack) next_state = GET_B;
         GET_B:   if (input_b_stb && input_b_ack) next_state = UNPACK;
         UNPACK:  next_state = SPECIAL;
         SPECIAL: next_state = special_hit ? PUT_Z : ALIGN;
         ALIGN:   if (a_e == b_e) next_state = ADD0;
         ADD0:    next_state = ADD1;
         ADD1:    next_state = NORM1;
         NORM1:   if (!(z_m[23] == 1'b0 && z_e > -10'sd126)) next_state = NORM2;
         NORM2:   if (!(z_e < -10'sd126)) next_state = ROUND;
         ROUND:   next_state = PACK;
         PACK:    next_state = PUT_Z;
         PUT_Z:   if (output_z_stb && output_z_ack) next_state = GET_A;
         default: next_state = GET_A;
      endcase
   end

   // Special-operand decode: NaN, infinity and zero shortcuts (b already negated in b_s)
   always_comb begin
      a_nan  = (&a[30:23]) && (|a[22:0]);
      b_nan  = (&b[30:23]) && (|b[22:0]);
      a_inf  = (&a[30:23]) && !(|a[22:0]);
      b_inf  = (&b[30:23]) && !(|b[22:0]);
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      special_hit = 1'b1;
      special_z   = 32'h7FC0_0000;
      if (a_nan || b_nan) begin
         special_z = 32'h7FC0_0000;
      end else if (a_inf) begin
         if (b_inf && (a_s != b_s)) special_z = 32'h7FC0_0000;
         else                       special_z = {a_s, 8'hFF, 23'd0};
      end else if (b_inf) begin
         special_z = {b_s, 8'hFF, 23'd0};
      end else if (a_zero && b_zero) begin
         special_z = {a_s & b_s, 31'd0};
      end else if (a_zero) begin
         special_z = {b_s, b[30:0]};
      end else if (b_zero) begin
         special_z = a;
      end else begin
         special_hit = 1'b0;
      end
   end

   // Registered handshakes and arithmetic datapath, one step per state
   always_ff @(posedge clk) begin
      if (rst) begin
         input_a_ack  <= 1'b0;
         input_b_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= 32'd0;
      end else begin
         input_a_ack  <= (next_state == GET_A);
         input_b_ack  <= (next_state == GET_B);
         output_z_stb <= (next_state == PUT_Z);
         case (state)
            GET_A: if (input_a_stb && input_a_ack) a <= input_a;
            GET_B: if (input_b_stb && input_b_ack) b <= input_b;
            UNPACK: begin
               a_m <= {(|a[30:23]), a[22:0], 3'b000};
               b_m <= {(|b[30:23]), b[22:0], 3'b000};
               a_e <= (a[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, a[30:23]}) - 10'sd127;
               b_e <= (b[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, b[30:23]}) - 10'sd127;
               a_s <= a[31];
               b_s <= ~b[31];
            end
            SPECIAL: if (special_hit) output_z <= special_z;
            ALIGN: begin
               if (a_e > b_e) begin
                  b_e <= b_e + 10'sd1;
                  b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
               end else if (a_e < b_e) begin
                  a_e <= a_e + 10'sd1;
                  a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
               end
            end
            ADD0: begin
               z_e <= a_e;
               if (a_s == b_s) begin
                  sum <= {1'b0, a_m} + {1'b0, b_m};
                  z_s <= a_s;
               end else if (a_m > b_m) begin
                  sum <= {1'b0, a_m} - {1'b0, b_m};
                  z_s <= a_s;
               end else if (a_m < b_m) begin
                  sum <= {1'b0, b_m} - {1'b0, a_m};
                  z_s <= b_s;
               end else begin
                  sum <= 28'd0;
                  z_s <= 1'b0;
               end
            end
            ADD1: begin
               if (sum[27]) begin
                  z_m       <= sum[27:4];
                  guard     <= sum[3];
                  round_bit <= sum[2];
                  sticky    <= sum[1] | sum[0];
                  z_e       <= z_e + 10'sd1;
               end else begin
                  z_m       <= sum[26:3];
                  guard     <= sum[2];
                  round_bit <= sum[1];
                  sticky    <= sum[0];
               end
            end
            NORM1: begin
               if (z_m[23] == 1'b0 && z_e > -10'sd126) begin
                  z_e       <= z_e - 10'sd1;
                  z_m       <= {z_m[22:0], guard};
                  guard     <= round_bit;
                  round_bit <= 1'b0;
               end
            end
            NORM2: begin
               if (z_e < -10'sd126) begin
                  z_e       <= z_e + 10'sd1;
                  z_m       <= {1'b0, z_m[23:1]};
                  guard     <= z_m[0];
                  round_bit <= guard;
                  sticky    <= sticky | round_bit;
               end
            end
            ROUND: begin
               if (guard && (round_bit || sticky || z_m[0])) begin
                  z_m <= z_m + 24'd1;
                  if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
               end
            end
            PACK: begin
               if (z_e > 10'sd127)
                  output_z <= {z_s, 8'hFF, 23'd0};
               else if (z_e == -10'sd126 && !z_m[23])
                  output_z <= {z_s, 8'h00, z_m[22:0]};
               else
                  output_z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_subtractor.sv
// tb/tb_fp32_subtractor.sv - directed self-checking bench for fp32_subtractor
module tb_fp32_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a, input_b;
   logic        input_a_stb, input_b_stb;
   logic        input_a_ack, input_b_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int errors = 0;
   int checks = 0;

   fp32_subtractor dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .input_b      (input_b),
      .input_b_stb  (input_b_stb),
      .input_b_ack  (input_b_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_a(input logic [31:0] v);
      int n;
      input_a = v;
      input_a_stb = 1'b1;
      n = 0;
      while (input_a_ack !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("a_ack_timeout", {31'd0, input_a_ack}, 32'd1);
      @(posedge clk);
      #1 input_a_stb = 1'b0;
      input_a = 32'hDEAD_BEEF;
   endtask

   task automatic send_b(input logic [31:0] v);
      int n;
      input_b = v;
      input_b_stb = 1'b1;
      n = 0;
      while (input_b_ack !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b_ack_timeout", {31'd0, input_b_ack}, 32'd1);
      @(posedge clk);
      #1 input_b_stb = 1'b0;
      input_b = 32'hBAAD_F00D;
   endtask

   task automatic get_z(input string tag, input logic [31:0] exp);
      int n;
      output_z_ack = 1'b1;
      n = 0;
      while (output_z_stb !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_stb"}, {31'd0, output_z_stb}, 32'd1);
      check(tag, output_z, exp);
      @(posedge clk);
      #1 output_z_ack = 1'b0;
   endtask

   task automatic op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] exp);
      send_a(va);
      send_b(vb);
      get_z(tag, exp);
   endtask

   logic [31:0] bb_a [3];
   logic [31:0] bb_b [3];
   logic [31:0] bb_z [3];

   initial begin
      int ia, ib, nz;
      logic a_x, b_x, z_x;

      rst = 1'b1;
      input_a = 32'd0; input_b = 32'd0;
      input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
      check("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
      check("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
      check("rst_z", output_z, 32'd0);
      rst = 1'b0;

      op("sub_15_75_7_25", 32'h417C_0000, 32'h40E8_0000, 32'h4108_0000);
      op("zero_minus_b",   32'h0000_0000, 32'h40E8_0000, 32'hC0E8_0000);
      op("equal_cancel",   32'h40E8_0000, 32'h40E8_0000, 32'h0000_0000);
      op("inf_minus_inf",  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
      op("one_minus_ulp",  32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF);
      op("denormal",       32'h0000_0001, 32'h0000_0002, 32'h8000_0001);
      op("one_minus_neg1", 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000);
      op("two_minus_three",32'h4000_0000, 32'h4040_0000, 32'hBF80_0000);
      op("nan_in",         32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
      op("inf_minus_one",  32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
      op("one_minus_inf",  32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000);
      op("negz_minus_z",   32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
      op("b_zero",         32'hC0E8_0000, 32'h0000_0000, 32'hC0E8_0000);
      op("overflow_inf",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000);
      op("tie_even_down",  32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000);
      op("tie_odd_up",     32'h3F80_0001, 32'hB380_0000, 32'h3F80_0002);

      // back-to-back with stb/ack held high
      bb_a[0] = 32'h417C_0000; bb_b[0] = 32'h40E8_0000; bb_z[0] = 32'h4108_0000;
      bb_a[1] = 32'h4000_0000; bb_b[1] = 32'h4040_0000; bb_z[1] = 32'hBF80_0000;
      bb_a[2] = 32'h40E8_0000; bb_b[2] = 32'h40E8_0000; bb_z[2] = 32'h0000_0000;
      ia = 0; ib = 0; nz = 0;
      input_a = bb_a[0]; input_b = bb_b[0];
      input_a_stb = 1'b1; input_b_stb = 1'b1; output_z_ack = 1'b1;
      for (int cyc = 0; cyc < 2000 && nz < 3; cyc++) begin
         @(negedge clk);
         a_x = input_a_ack; b_x = input_b_ack; z_x = output_z_stb;
         if (z_x) begin
            check("b2b_z", output_z, bb_z[nz]);
            nz++;
         end
         @(posedge clk);
         #1;
         if (a_x) begin ia++; input_a = bb_a[ia % 3]; end
         if (b_x) begin ib++; input_b = bb_b[ib % 3]; end
      end
      input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
      check("b2b_count", nz, 32'd3);
      @(negedge clk);

      // result held while consumer stalls
      send_a(32'h417C_0000);
      send_b(32'h40E8_0000);
      output_z_ack = 1'b0;
      begin
         int n;
         n = 0;
         while (output_z_stb !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("hold_stb", {31'd0, output_z_stb}, 32'd1);
         check("hold_z", output_z, 32'h4108_0000);
         check("hold_a_ack", {31'd0, input_a_ack}, 32'd0);
      end
      get_z("hold_release", 32'h4108_0000);

      // reset in the middle of a long alignment
      send_a(32'h3F80_0000);
      send_b(32'h3380_0000);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_a_ack", {31'd0, input_a_ack}, 32'd0);
      check("mid_rst_b_ack", {31'd0, input_b_ack}, 32'd0);
      check("mid_rst_z_stb", {31'd0, output_z_stb}, 32'd0);
      check("mid_rst_z", output_z, 32'd0);
      rst = 1'b0;
      op("after_rst", 32'h417C_0000, 32'h40E8_0000, 32'h4108_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
